// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               almost-full/almost-empty flags and a read-valid strobe.
//               Optional sticky overflow/underflow flags: FIFO_ERR_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]  c_AF_CNT   = (c_AW + 1)'(AF_LEVEL);
    localparam logic [c_AW:0]  c_AE_CNT   = (c_AW + 1)'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_data_out;
    logic             r_rd_valid;
    logic [c_AW:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;

    // Wrap bit makes the modular difference span 0..DEPTH inclusive.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == c_FULL_CNT);
    assign w_empty  = (w_count == '0);
    assign w_rd_acc = rd & ~w_empty;
    assign w_wr_acc = wr & (~w_full | w_rd_acc);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
        end
    end

    // Storage is deliberately not reset; when full with a concurrent read the
    // write lands on the slot being read, and the read still sees the old word.
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= data_in;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr & ~w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd & w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign data_out     = r_data_out;
    assign rd_valid     = r_rd_valid;
    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= c_AF_CNT);
    assign almost_empty = (w_count <= c_AE_CNT);

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=16,
//               AF_LEVEL=14, AE_LEVEL=2); covers FIFO_ERR_FLAGS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 16;

    logic             clock;
    logic             rst_n;
    logic             wr;
    logic             rd;
    logic [7:0]       data_in;
    logic [7:0]       data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
    logic             err_clr;
`endif

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [7:0]       sb_q[$];

    sync_fifo_param #(
        .WIDTH    (c_WIDTH),
        .DEPTH    (c_DEPTH),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr),
`endif
        .count        (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and held for one cycle.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr      = w;
        rd      = r;
        data_in = d;
        @(posedge clock);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected word.
    always @(negedge clock) begin
        if (rst_n && rd_valid) begin
            if (sb_q.size() == 0) begin
                check("rd_valid_unexpected", {31'd0, rd_valid}, 32'd0);
            end else begin
                check("data_out", {24'd0, data_out}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        data_in = '0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        check("rst_count",    {27'd0, count}, 32'd0);
        check("rst_empty",    {31'd0, empty}, 32'd1);
        check("rst_aempty",   {31'd0, almost_empty}, 32'd1);
        check("rst_full",     {31'd0, full}, 32'd0);
        check("rst_afull",    {31'd0, almost_full}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;

        // 1. Fill
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            check("fill_count",  {27'd0, count}, 32'(i));
            check("fill_afull",  {31'd0, almost_full}, {31'd0, (i >= 14)});
            check("fill_full",   {31'd0, full}, {31'd0, (i == 16)});
            check("fill_aempty", {31'd0, almost_empty}, {31'd0, (i <= 2)});
        end
        cyc(1'b1, 1'b0, 8'h11);
        check("overwrite_count", {27'd0, count}, 32'd16);

        // 2. Drain
        for (int i = 1; i <= 16; i++) begin
            sb_q.push_back(8'(i));
            cyc(1'b0, 1'b1, 8'h00);
            check("drain_rd_valid", {31'd0, rd_valid}, 32'd1);
        end
        cyc(1'b0, 1'b0, 8'h00);
        check("drain_empty",  {31'd0, empty}, 32'd1);
        check("drain_aempty", {31'd0, almost_empty}, 32'd1);
        check("drain_sb",     32'(sb_q.size()), 32'd0);

        // 3. Full with simultaneous read and write
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
        sb_q.push_back(8'h01);
        cyc(1'b1, 1'b1, 8'hEE);
        check("rw_full_count", {27'd0, count}, 32'd16);
        check("rw_full_full",  {31'd0, full}, 32'd1);
        for (int i = 2; i <= 16; i++) begin
            sb_q.push_back(8'(i));
            cyc(1'b0, 1'b1, 8'h00);
        end
        sb_q.push_back(8'hEE);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("rw_full_empty", {31'd0, empty}, 32'd1);
        check("rw_full_sb",    32'(sb_q.size()), 32'd0);

        // 4. Empty with simultaneous read and write
        cyc(1'b1, 1'b1, 8'hA5);
        check("rw_empty_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rw_empty_count",    {27'd0, count}, 32'd1);
        sb_q.push_back(8'hA5);
        cyc(1'b0, 1'b1, 8'h00);
        check("rw_empty_rd_valid2", {31'd0, rd_valid}, 32'd1);
        cyc(1'b0, 1'b0, 8'h00);

        // 5. Wrap-around with ramp data
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 8'(i * 3 + 7));
            sb_q.push_back(8'(i * 3 + 7));
            cyc(1'b0, 1'b1, 8'h00);
        end
        cyc(1'b0, 1'b0, 8'h00);
        check("wrap_sb",    32'(sb_q.size()), 32'd0);
        check("wrap_empty", {31'd0, empty}, 32'd1);

        // Asynchronous reset with data held
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h50 + 8'(i));
        check("pre_arst_count", {27'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", {27'd0, count}, 32'd0);
        check("arst_empty", {31'd0, empty}, 32'd1);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h77);
        check("post_arst_count", {27'd0, count}, 32'd1);
        sb_q.push_back(8'h77);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

`ifdef FIFO_ERR_FLAGS_EN
        // 6. Sticky error flags
        check("ovf_init", {31'd0, overflow}, 32'd0);
        check("udf_init", {31'd0, underflow}, 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i));
        cyc(1'b1, 1'b0, 8'hFF);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(8'h20 + 8'(i));
            cyc(1'b0, 1'b1, 8'h00);
        end
        cyc(1'b0, 1'b1, 8'h00);
        check("udf_set", {31'd0, underflow}, 32'd1);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);
        check("udf_clr", {31'd0, underflow}, 32'd0);
`endif

        cyc(1'b0, 1'b0, 8'h00);
        check("final_sb", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
